// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    // Controller states: wait for operands, walk the chunks, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Comparison result; exactly one flag is set while a result is valid.
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit comparator. When sgn is set, the chunk is treated
// as the top slice of a two's-complement value: flipping its top bit on both
// sides turns signed order into plain unsigned order.
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             sgn,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    logic [CHUNK-1:0] x_m;
    logic [CHUNK-1:0] y_m;

    // Optional sign-bit flip followed by an unsigned compare.
    always_comb begin
        x_m = x;
        y_m = y;
        if (sgn) begin
            x_m[CHUNK-1] = ~x[CHUNK-1];
            y_m[CHUNK-1] = ~y[CHUNK-1];
        end
        gt = (x_m > y_m);
        eq = (x_m == y_m);
        lt = (x_m < y_m);
    end

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle magnitude comparator: compares a and b CHUNK bits per cycle,
// MSB chunk first, stopping at the first unequal chunk.
// Build option: define SEQ_MAG_COMPARE_SIGNED_EN for two's-complement operands.
module seq_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int NCHUNK = nchunk(WIDTH, CHUNK),
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("seq_mag_compare: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    cmp_res_t         res_q, res_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    // Slice the captured operands into chunks, index 0 being the MSB chunk.
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
        assign a_chunk[gi] = a_q[WIDTH-1-gi*CHUNK -: CHUNK];
        assign b_chunk[gi] = b_q[WIDTH-1-gi*CHUNK -: CHUNK];
    end

    logic sgn;
    logic c_gt, c_eq, c_lt;

`ifdef SEQ_MAG_COMPARE_SIGNED_EN
    // Only the MSB chunk carries the sign.
    assign sgn = (idx_q == '0);
`else
    assign sgn = 1'b0;
`endif

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .x   (a_chunk[idx_q]),
        .y   (b_chunk[idx_q]),
        .sgn (sgn),
        .gt  (c_gt),
        .eq  (c_eq),
        .lt  (c_lt)
    );

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            res_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state logic: capture in IDLE, walk chunks in RUN, hold result in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        res_d    = res_q;
        cycles_d = cycles_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!c_eq) begin
                    res_d.gt = c_gt;
                    res_d.eq = 1'b0;
                    res_d.lt = c_lt;
                    cycles_d = CW'(idx_q) + CW'(1);
                    state_d  = DONE;
                end else if (idx_q == IW'(NCHUNK - 1)) begin
                    res_d.gt = 1'b0;
                    res_d.eq = 1'b1;
                    res_d.lt = 1'b0;
                    cycles_d = CW'(NCHUNK);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gt        = res_q.gt;
    assign eq        = res_q.eq;
    assign lt        = res_q.lt;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench for seq_mag_compare (WIDTH=16, CHUNK=4).
// Expected results come from a chunk-walking reference model and travel
// through a scoreboard queue from the accept edge to the result.
module tb_seq_mag_compare;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [CW-1:0]    cycles;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             gt;
        logic             eq;
        logic             lt;
        int               cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_mag_compare #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk chunks MSB first, first difference decides.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t e;
        logic [CHUNK-1:0] ca, cb;
        e.a = av; e.b = bv;
        e.gt = 1'b0; e.eq = 1'b1; e.lt = 1'b0; e.cycles = NCHUNK;
        for (int i = 0; i < NCHUNK; i++) begin
            ca = CHUNK'(av >> (WIDTH - (i + 1) * CHUNK));
            cb = CHUNK'(bv >> (WIDTH - (i + 1) * CHUNK));
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
            if (i == 0) begin
                ca[CHUNK-1] = ~ca[CHUNK-1];
                cb[CHUNK-1] = ~cb[CHUNK-1];
            end
`endif
            if (ca != cb) begin
                e.gt = (ca > cb);
                e.lt = (ca < cb);
                e.eq = 1'b0;
                e.cycles = i + 1;
                return e;
            end
        end
        return e;
    endfunction

    // One full transaction: offer operands, wait for result, hold it for
    // hold_cyc cycles with out_ready low, then release it.
    task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int hold_cyc);
        exp_t e;
        int   lat;
        logic [CW-1:0] cyc_seen;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(model(av, bv));
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        $display("[TB] a=%04h b=%04h -> gt=%0b eq=%0b lt=%0b cycles=%0d latency=%0d",
                 av, bv, gt, eq, lt, cycles, lat);
        check("latency", 32'(lat), 32'(e.cycles));
        check("gt", 32'(gt), 32'(e.gt));
        check("eq", 32'(eq), 32'(e.eq));
        check("lt", 32'(lt), 32'(e.lt));
        check("cycles", 32'(cycles), 32'(e.cycles));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        cyc_seen = cycles;
        for (int h = 0; h < hold_cyc; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_flags", 32'({gt, eq, lt}), 32'({e.gt, e.eq, e.lt}));
            check("hold_cycles", 32'(cycles), 32'(e.cycles));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_flags", 32'({gt, eq, lt}), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_cycles_held", 32'(cycles), 32'(cyc_seen));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_flags", 32'({gt, eq, lt}), 32'd0);
        check("reset_cycles", 32'(cycles), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_cmp(16'h1234, 16'h1234, 0);
        run_cmp(16'h9000, 16'h8FFF, 0);
        run_cmp(16'h12F0, 16'h12F1, 0);
        run_cmp(16'h8000, 16'h0001, 0);
        run_cmp(16'h0001, 16'h8000, 0);
        run_cmp(16'h0000, 16'h0000, 0);
        run_cmp(16'hFFFF, 16'hFFFF, 0);
        run_cmp(16'h7FFF, 16'hFFFF, 0);
        run_cmp(16'hABCD, 16'hAB0D, 5);

        // Asynchronous reset in the middle of RUN.
        a = 16'h1230; b = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_flags", 32'({gt, eq, lt}), 32'd0);
        check("async_rst_cycles", 32'(cycles), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_cmp(16'h1230, 16'h1234, 0);

        // Random pairs, half of them sharing high-order chunks.
        for (int i = 0; i < 12; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 2 == 0) ? ((ra & 16'hFF00) | WIDTH'($urandom_range(0, 255))) : WIDTH'($urandom);
            run_cmp(ra, rb, i % 3);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
